// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and payload type for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_X0 = RF_ADDR_W'(0);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback buffer: captures a request on load, empties on drain.
module rf_wb_slot
  import rf_wb_arbiter_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_load,
  input  logic    i_drain,
  input  wb_req_t i_req,
  output logic    o_full,
  output wb_req_t o_req
);

  // Load wins over drain so a drained slot can refill in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_full <= 1'b0;
      o_req  <= '0;
    end else if (i_load) begin
      o_full <= 1'b1;
      o_req  <= i_req;
    end else if (i_drain) begin
      o_full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit          RR_EN      = 1'b1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [RF_ADDR_W-1:0] i_req0_waddr,
  input  logic [RF_DATA_W-1:0] i_req0_wdata,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [RF_ADDR_W-1:0] i_req1_waddr,
  input  logic [RF_DATA_W-1:0] i_req1_wdata,
  output logic                 o_rd_wen,
  output logic [RF_ADDR_W-1:0] o_rd_waddr,
  output logic [RF_DATA_W-1:0] o_rd_wdata,
  output logic                 o_busy
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic                slot0_full;
  logic                slot1_full;
  wb_req_t             slot0_req;
  wb_req_t             slot1_req;
  logic                gnt0_c;
  logic                gnt1_c;
  logic                load0_c;
  logic                load1_c;
  wb_req_t             sel_req_c;
  logic                last_gnt1;
  logic [STARVE_W-1:0] starve_cnt;

  assign o_req0_ready = ~slot0_full | gnt0_c;
  assign o_req1_ready = ~slot1_full | gnt1_c;
  assign load0_c      = i_req0_valid & o_req0_ready;
  assign load1_c      = i_req1_valid & o_req1_ready;

  rf_wb_slot u_slot0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load0_c),
    .i_drain (gnt0_c),
    .i_req   ('{addr: i_req0_waddr, data: i_req0_wdata}),
    .o_full  (slot0_full),
    .o_req   (slot0_req)
  );

  rf_wb_slot u_slot1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load1_c),
    .i_drain (gnt1_c),
    .i_req   ('{addr: i_req1_waddr, data: i_req1_wdata}),
    .o_full  (slot1_full),
    .o_req   (slot1_req)
  );

  // Grant depends only on slot state, keeping ready free of valid.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (slot0_full && slot1_full) begin
      if (RR_EN) begin
        gnt0_c = last_gnt1;
        gnt1_c = ~last_gnt1;
      end else if (starve_cnt == STARVE_LIM) begin
        gnt1_c = 1'b1;
      end else begin
        gnt0_c = 1'b1;
      end
    end else begin
      gnt0_c = slot0_full;
      gnt1_c = slot1_full;
    end
  end

  assign sel_req_c = gnt1_c ? slot1_req : slot0_req;

  // Registered write stage; x0 writes are drained without raising the enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= '0;
      o_rd_wdata <= '0;
      last_gnt1  <= 1'b1;
    end else if (gnt0_c || gnt1_c) begin
      o_rd_wen   <= (sel_req_c.addr != RF_X0);
      o_rd_waddr <= sel_req_c.addr;
      o_rd_wdata <= sel_req_c.data;
      last_gnt1  <= gnt1_c;
    end else begin
      o_rd_wen   <= 1'b0;
    end
  end

  // Counts cycles req1 sits blocked behind req0 in fixed-priority mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (RR_EN || !slot1_full || gnt1_c) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign o_busy = slot0_full | slot1_full | o_rd_wen;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances share stimulus.
module tb_rf_wb_arbiter;

  localparam int STARVE_FP = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  logic [1:0]       rdy0, rdy1, wen, busy;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  rf_wb_arbiter #(.RR_EN(1'b1), .STARVE_MAX(4)) u_rr (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0[0]), .i_req0_waddr(a0), .i_req0_wdata(d0),
    .i_req1_valid(v1), .o_req1_ready(rdy1[0]), .i_req1_waddr(a1), .i_req1_wdata(d1),
    .o_rd_wen(wen[0]), .o_rd_waddr(waddr[0]), .o_rd_wdata(wdata[0]), .o_busy(busy[0])
  );

  rf_wb_arbiter #(.RR_EN(1'b0), .STARVE_MAX(STARVE_FP)) u_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0[1]), .i_req0_waddr(a0), .i_req0_wdata(d0),
    .i_req1_valid(v1), .o_req1_ready(rdy1[1]), .i_req1_waddr(a1), .i_req1_wdata(d1),
    .o_rd_wen(wen[1]), .o_rd_waddr(waddr[1]), .o_rd_wdata(wdata[1]), .o_busy(busy[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: per instance, one pending write per source plus arbitration history.
  bit          m_full [2][2];
  logic [4:0]  m_addr [2][2];
  logic [31:0] m_data [2][2];
  bit          m_last1 [2];
  int          m_starve [2];
  bit          m_wen [2];
  logic [36:0] expq0[$];
  logic [36:0] expq1[$];

  // Instance 0 alternates on contention; instance 1 prefers req0 until req1 waited STARVE_FP cycles.
  function automatic int model_gnt(int i);
    if (m_full[i][0] && m_full[i][1]) begin
      if (i == 0) return m_last1[i] ? 0 : 1;
      return (m_starve[i] == STARVE_FP) ? 1 : 0;
    end
    if (m_full[i][0]) return 0;
    if (m_full[i][1]) return 1;
    return -1;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 2; k++) m_full[i][k] <= 1'b0;
        m_last1[i]  <= 1'b1;
        m_starve[i] <= 0;
        m_wen[i]    <= 1'b0;
      end
      expq0.delete();
      expq1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        int g;
        g = model_gnt(i);
        if (g >= 0) begin
          m_wen[i]   <= (m_addr[i][g] != 5'd0);
          m_last1[i] <= (g == 1);
          if (m_addr[i][g] != 5'd0) begin
            if (i == 0) expq0.push_back({m_addr[i][g], m_data[i][g]});
            else        expq1.push_back({m_addr[i][g], m_data[i][g]});
          end
        end else begin
          m_wen[i] <= 1'b0;
        end
        if (!m_full[i][1] || g == 1) m_starve[i] <= 0;
        else if (m_starve[i] < STARVE_FP) m_starve[i] <= m_starve[i] + 1;
        for (int k = 0; k < 2; k++) begin
          bit vv;
          vv = (k == 0) ? v0 : v1;
          if (vv && (!m_full[i][k] || g == k)) begin
            m_full[i][k] <= 1'b1;
            m_addr[i][k] <= (k == 0) ? a0 : a1;
            m_data[i][k] <= (k == 0) ? d0 : d1;
          end else if (g == k) begin
            m_full[i][k] <= 1'b0;
          end
        end
      end
    end
  end

  logic [4:0] log0[$], log1[$];
  int         logcyc0[$];

  // Monitor: pops expected writes whenever a DUT presents one.
  always @(negedge i_clk) begin
    if (!i_rst && mon_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [36:0] e;
        int g;
        g = model_gnt(i);
        chk($sformatf("ready0[%0d]", i), longint'(rdy0[i]), longint'(!m_full[i][0] || g == 0));
        chk($sformatf("ready1[%0d]", i), longint'(rdy1[i]), longint'(!m_full[i][1] || g == 1));
        chk($sformatf("busy[%0d]", i), longint'(busy[i]),
            longint'(m_full[i][0] | m_full[i][1] | m_wen[i]));
        chk($sformatf("wen[%0d]", i), longint'(wen[i]), longint'(m_wen[i]));
        if (wen[i]) begin
          if (i == 0) begin
            log0.push_back(waddr[i]);
            logcyc0.push_back(cyc);
          end else begin
            log1.push_back(waddr[i]);
          end
          if ((i == 0 && expq0.size() == 0) || (i == 1 && expq1.size() == 0)) begin
            chk($sformatf("unexpected_write[%0d]", i), 1, 0);
          end else begin
            e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
            chk($sformatf("waddr[%0d]", i), longint'(waddr[i]), longint'(e[36:32]));
            chk($sformatf("wdata[%0d]", i), longint'(wdata[i]), longint'(e[31:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, nw;
    bit acc0, acc1;
    logic [4:0] exp3 [8];
    logic [4:0] exp5 [7];
    exp3 = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    exp5 = '{5'd1, 5'd2, 5'd3, 5'd20, 5'd4, 5'd5, 5'd6};

    // Reset values.
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wen", longint'(wen[i]), 0);
      chk("rst_waddr", longint'(waddr[i]), 0);
      chk("rst_wdata", longint'(wdata[i]), 0);
      chk("rst_busy", longint'(busy[i]), 0);
      chk("rst_ready0", longint'(rdy0[i]), 1);
      chk("rst_ready1", longint'(rdy1[i]), 1);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    mon_en = 1'b1;

    // Single req0 write to x5.
    @(negedge i_clk);
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    @(negedge i_clk);
    v0 = 1'b0;
    for (int i = 0; i < 2; i++) chk("t2_wen_early", longint'(wen[i]), 0);
    @(negedge i_clk);
    for (int i = 0; i < 2; i++) begin
      chk("t2_wen", longint'(wen[i]), 1);
      chk("t2_waddr", longint'(waddr[i]), 5);
      chk("t2_wdata", longint'(wdata[i]), 32'hDEADBEEF);
    end
    @(negedge i_clk);
    for (int i = 0; i < 2; i++) chk("t2_wen_once", longint'(wen[i]), 0);

    // req1 write to x0: accepted, dropped.
    @(negedge i_clk);
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    for (int i = 0; i < 2; i++) chk("t4_ready1", longint'(rdy1[i]), 1);
    @(negedge i_clk);
    v1 = 1'b0;
    for (int i = 0; i < 2; i++) chk("t4_busy_held", longint'(busy[i]), 1);
    @(negedge i_clk);
    for (int i = 0; i < 2; i++) begin
      chk("t4_busy_drop", longint'(busy[i]), 0);
      chk("t4_no_wen", longint'(wen[i]), 0);
    end

    // Round-robin: both sources saturated, paced by the round-robin instance.
    repeat (3) @(negedge i_clk);
    log0.delete(); logcyc0.delete();
    i0 = 0; i1 = 0; acc0 = 0; acc1 = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge i_clk);
      if (acc0) i0++;
      if (acc1) i1++;
      v0 = (i0 < 4); a0 = 5'(1 + i0);  d0 = $urandom;
      v1 = (i1 < 4); a1 = 5'(11 + i1); d1 = $urandom;
      acc0 = v0 && rdy0[0];
      acc1 = v1 && rdy1[0];
      if (!v0 && !v1) break;
    end
    v0 = 1'b0; v1 = 1'b0;
    for (int t = 0; t < 20 && log0.size() < 8; t++) @(negedge i_clk);
    chk("t3_count", longint'(log0.size()), 8);
    if (log0.size() >= 8) begin
      for (int j = 0; j < 8; j++) chk($sformatf("t3_order%0d", j), longint'(log0[j]), longint'(exp3[j]));
      chk("t3_back_to_back", longint'(logcyc0[7] - logcyc0[0]), 7);
    end

    // Fixed priority: req1 forced through after STARVE_FP req0 writes.
    repeat (3) @(negedge i_clk);
    log1.delete();
    i0 = 0; i1 = 0; acc0 = 0; acc1 = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge i_clk);
      if (acc0) i0++;
      if (acc1) i1++;
      v0 = (i0 < 6); a0 = 5'(1 + i0); d0 = $urandom;
      v1 = (i1 < 1); a1 = 5'd20;      d1 = $urandom;
      acc0 = v0 && rdy0[1];
      acc1 = v1 && rdy1[1];
      if (!v0 && !v1) break;
    end
    v0 = 1'b0; v1 = 1'b0;
    for (int t = 0; t < 20 && log1.size() < 7; t++) @(negedge i_clk);
    chk("t5_count", longint'(log1.size()), 7);
    if (log1.size() >= 7)
      for (int j = 0; j < 7; j++) chk($sformatf("t5_order%0d", j), longint'(log1[j]), longint'(exp5[j]));

    // Reset with both slots full discards everything.
    repeat (3) @(negedge i_clk);
    v0 = 1'b1; a0 = 5'd9;  d0 = 32'h99;
    v1 = 1'b1; a1 = 5'd10; d1 = 32'h1010;
    @(negedge i_clk);
    v0 = 1'b0; v1 = 1'b0;
    #1 i_rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t1_wen", longint'(wen[i]), 0);
      chk("t1_ready0", longint'(rdy0[i]), 1);
      chk("t1_ready1", longint'(rdy1[i]), 1);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    nw = 0;
    repeat (6) begin
      @(negedge i_clk);
      nw += int'(wen[0]) + int'(wen[1]);
    end
    chk("t1_no_write_after_reset", longint'(nw), 0);

    // Randomized traffic.
    repeat (1500) begin
      @(negedge i_clk);
      v0 = 1'($urandom); a0 = 5'($urandom); d0 = $urandom;
      v1 = 1'($urandom); a1 = 5'($urandom); d1 = $urandom;
    end
    @(negedge i_clk);
    v0 = 1'b0; v1 = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("drain_q0", longint'(expq0.size()), 0);
    chk("drain_q1", longint'(expq1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
